muldiv_seq: RTL and testbench
=============================

// Module: muldiv_seq
// PURPOSE
//  Iterative signed multiply/divide sequencer for the multicycle CPU's HI/LO resource.
//  The control unit issues a one-cycle start with an opcode and two operands (A/B regs).
//  The block runs WIDTH shift-add/restoring iterations and returns a 2*WIDTH result
//  with a write pulse feeding the HI and LO registers. It flags divide-by-zero.
//  Results follow MIPS semantics.
// PARAMETERS
//  WIDTH    32   operand width; result is 2*WIDTH split into HI/LO
//  CNT_W    5    iteration counter width; must satisfy 2**CNT_W >= WIDTH
// PORTS
//  clk        in   1      clock, all state updates on rising edge
//  reset      in   1      synchronous, active-low (0 = reset)
//  start      in   1      request pulse; sampled only in IDLE
//  op         in   1      0 = MULT (signed), 1 = DIV (signed); captured with start
//  a          in   WIDTH  multiplicand / dividend; captured with start
//  b          in   WIDTH  multiplier / divisor; captured with start
//  busy       out  1      high from the cycle after start is accepted until DONE exits
//  done       out  1      one-cycle completion pulse
//  hi_lo_w    out  1      one-cycle write enable for HI/LO; coincides with done unless div_zero
//  div_zero   out  1      high with done when DIV had b==0; cleared at next accepted start
//  hi_res     out  WIDTH  MULT: product[2W-1:W]; DIV: remainder
//  lo_res     out  WIDTH  MULT: product[W-1:0]; DIV: quotient
// BEHAVIOUR
//  Reset (reset==0 at edge): state=IDLE, counter=0, all outputs 0, internal regs 0.
//   Reset mid-operation aborts immediately. No done or hi_lo_w is produced for the aborted op.
//  FSM states: IDLE -> {MUL_IT | DIV_IT | DONE} -> FIX -> DONE -> IDLE.
//   IDLE: on start=1, capture |a|, |b|, result signs, and op.
//    Counter loads WIDTH-1 and div_zero clears.
//    Next state is MUL_IT if op=0, DIV_IT if op=1 and b!=0.
//    If op=1 and b==0: next state is DONE with div_zero=1.
//   MUL_IT: unsigned shift-add over 2W accumulator, one multiplier bit per cycle, LSB first.
//    When counter==0, go to FIX; otherwise decrement counter.
//   DIV_IT: restoring division, one quotient bit per cycle, MSB first.
//    Remainder register is WIDTH+1 bits. Same counter rule.
//   FIX: apply signs.
//    MULT: negate the 2W product if sign(a)!=sign(b).
//    DIV: negate quotient if sign(a)!=sign(b); remainder takes the sign of a.
//    Quotient truncates toward zero.
//   DONE: load hi_res/lo_res; assert done=1.
//    Assert hi_lo_w=1 only if div_zero=0. Go to IDLE next cycle.
//  Latency: start sampled at edge E0 -> done high in the cycle after edge E0+WIDTH+2
//   (34 cycles for WIDTH=32).
//   Div-by-zero: done high in the cycle after E0+1.
//  On div-by-zero, hi_res/lo_res keep their previous values.
//  hi_res/lo_res are registered and hold between operations.
//  start while busy=1 or in DONE is ignored; no queueing.
//  start in the same cycle done is high is ignored; it is accepted the next cycle.
//  Operand magnitudes are unsigned WIDTH-bit, so |0x80000000| = 0x80000000 is exact.
//   0x80000000 / -1 gives LO=0x80000000, HI=0 with no trap.
//  op, a, and b are don't-care outside the start cycle.
// TESTING
//  1. MULT a=7, b=-3 -> after 34 cycles: done=1, hi_lo_w=1, hi_res=FFFFFFFF, lo_res=FFFFFFEB.
//  2. MULT a=b=80000000 -> hi_res=40000000, lo_res=00000000.
//     MULT a=FFFFFFFF, b=FFFFFFFF -> hi_res=0, lo_res=1.
//  3. DIV a=-7, b=2 -> lo_res=FFFFFFFD, hi_res=FFFFFFFF.
//     DIV a=7, b=-2 -> lo_res=FFFFFFFD, hi_res=00000001.
//     DIV a=80000000, b=FFFFFFFF -> lo_res=80000000, hi_res=0.
//  4. DIV a=5, b=0 with prior hi/lo=1234/5678 -> done 2 cycles after start.
//     Expect div_zero=1, hi_lo_w=0, hi_res/lo_res unchanged.
//     A following MULT start clears div_zero.
//  5. MULT 3*4 with start re-pulsed at cycles 5 and 20 (a=9, b=9) -> ignored; result lo_res=0000000C.
//     Only one done pulse.
//  6. reset=0 at cycle 10 of a DIV -> next cycle busy=0, done=0, hi/lo=0.
//     No hi_lo_w. A new MULT 2*2 completes normally with lo_res=4.

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative signed multiply/divide unit for the HI/LO resource.
// Multiplication uses shift-add. Division uses restoring steps. Both run WIDTH iterations on magnitudes, then apply the signs.
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             hi_lo_w,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_res,
    output logic [WIDTH-1:0] lo_res
);

    localparam int W2 = 2 * WIDTH;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MUL_IT = 3'd1,
        S_DIV_IT = 3'd2,
        S_FIX    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1'b1);
    endfunction

    // The most negative value maps onto itself, which is exactly its unsigned magnitude.
    function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? neg_w(x) : x;
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               op_q, op_d;
    logic               sa_q, sa_d;
    logic               neg_q, neg_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               hi_lo_w_q, hi_lo_w_d;
    logic               div_zero_q, div_zero_d;
    logic [WIDTH-1:0]   hi_res_q, hi_res_d;
    logic [WIDTH-1:0]   lo_res_q, lo_res_d;

    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH+1:0]   div_shift_s;
    logic [WIDTH+1:0]   div_diff_s;
    logic [W2-1:0]      prod_s;
    logic [W2-1:0]      prod_fix_s;

    // Datapath arithmetic shared by the iteration and fix-up states.
    always_comb begin
        mul_sum_s   = {1'b0, acc_q[WIDTH-1:0]} + {1'b0, (lo_q[0] ? opb_q : {WIDTH{1'b0}})};
        div_shift_s = {acc_q, lo_q[WIDTH-1]};
        div_diff_s  = div_shift_s - {2'b00, opb_q};
        prod_s      = {acc_q[WIDTH-1:0], lo_q};
        prod_fix_s  = neg_q ? (~prod_s + W2'(1'b1)) : prod_s;
    end

    // Next-state and datapath/output next values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        lo_d       = lo_q;
        opb_d      = opb_q;
        op_d       = op_q;
        sa_d       = sa_q;
        neg_d      = neg_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        hi_lo_w_d  = 1'b0;
        div_zero_d = div_zero_q;
        hi_res_d   = hi_res_q;
        lo_res_d   = lo_res_q;
        case (state_q)
            S_IDLE: begin
                // done_q gating drops a start that arrives during the completion pulse.
                if (start && !done_q) begin
                    op_d       = op;
                    sa_d       = a[WIDTH-1];
                    neg_d      = a[WIDTH-1] ^ b[WIDTH-1];
                    acc_d      = {(WIDTH+1){1'b0}};
                    lo_d       = op ? abs_w(a) : abs_w(b);
                    opb_d      = op ? abs_w(b) : abs_w(a);
                    cnt_d      = CNT_W'(WIDTH - 1);
                    busy_d     = 1'b1;
                    div_zero_d = op && (b == {WIDTH{1'b0}});
                    if (!op) begin
                        state_d = S_MUL_IT;
                    end else if (b == {WIDTH{1'b0}}) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DIV_IT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL_IT: begin
                acc_d = {1'b0, mul_sum_s[WIDTH:1]};
                lo_d  = {mul_sum_s[0], lo_q[WIDTH-1:1]};
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1'b1);
                end
            end
            S_DIV_IT: begin
                // A borrow out of the trial subtraction means the partial remainder is restored.
                if (div_diff_s[WIDTH+1]) begin
                    acc_d = div_shift_s[WIDTH:0];
                    lo_d  = {lo_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = div_diff_s[WIDTH:0];
                    lo_d  = {lo_q[WIDTH-2:0], 1'b1};
                end
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1'b1);
                end
            end
            S_FIX: begin
                if (op_q) begin
                    lo_d  = neg_q ? neg_w(lo_q) : lo_q;
                    acc_d = {1'b0, (sa_q ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0])};
                end else begin
                    acc_d = {1'b0, prod_fix_s[W2-1:WIDTH]};
                    lo_d  = prod_fix_s[WIDTH-1:0];
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                done_d    = 1'b1;
                hi_lo_w_d = !div_zero_q;
                busy_d    = 1'b0;
                if (!div_zero_q) begin
                    hi_res_d = acc_q[WIDTH-1:0];
                    lo_res_d = lo_q;
                end else begin
                    hi_res_d = hi_res_q;
                    lo_res_d = lo_res_q;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q      <= {CNT_W{1'b0}};
            acc_q      <= {(WIDTH+1){1'b0}};
            lo_q       <= {WIDTH{1'b0}};
            opb_q      <= {WIDTH{1'b0}};
            op_q       <= 1'b0;
            sa_q       <= 1'b0;
            neg_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hi_lo_w_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_res_q   <= {WIDTH{1'b0}};
            lo_res_q   <= {WIDTH{1'b0}};
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            lo_q       <= lo_d;
            opb_q      <= opb_d;
            op_q       <= op_d;
            sa_q       <= sa_d;
            neg_q      <= neg_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            hi_lo_w_q  <= hi_lo_w_d;
            div_zero_q <= div_zero_d;
            hi_res_q   <= hi_res_d;
            lo_res_q   <= lo_res_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign hi_lo_w  = hi_lo_w_q;
    assign div_zero = div_zero_q;
    assign hi_res   = hi_res_q;
    assign lo_res   = lo_res_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases plus random operations.
// The reference model uses 64-bit signed arithmetic.
module tb_muldiv_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        hi_lo_w;
    logic        div_zero;
    logic [31:0] hi_res;
    logic [31:0] lo_res;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_hi = 32'h0;
    logic [31:0] exp_lo = 32'h0;

    muldiv_seq #(.WIDTH(32), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi_lo_w(hi_lo_w), .div_zero(div_zero),
        .hi_res(hi_res), .lo_res(lo_res)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model(input bit op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                         output logic [31:0] hi_v, output logic [31:0] lo_v);
        longint sa, sb, r;
        logic [63:0] u;
        sa = longint'($signed(a_v));
        sb = longint'($signed(b_v));
        if (!op_v) begin
            r    = sa * sb;
            u    = r;
            hi_v = u[63:32];
            lo_v = u[31:0];
        end else begin
            r    = sa / sb;
            u    = r;
            lo_v = u[31:0];
            r    = sa % sb;
            u    = r;
            hi_v = u[31:0];
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic start_op(input bit op_v, input logic [31:0] a_v, input logic [31:0] b_v);
        start = 1'b1;
        op    = op_v;
        a     = a_v;
        b     = b_v;
        @(negedge clk);
        start = 1'b0;
        op    = $urandom_range(0, 1);
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic run_op(input string tag, input bit op_v, input logic [31:0] a_v, input logic [31:0] b_v);
        int m;
        bit dz;
        logic [31:0] mh, ml;
        dz = op_v && (b_v == 32'h0);
        if (!dz) begin
            model(op_v, a_v, b_v, mh, ml);
            exp_hi = mh;
            exp_lo = ml;
        end
        start_op(op_v, a_v, b_v);
        chk({tag, ".busy_start"}, 32'(busy), 32'h1);
        if (!dz) chk({tag, ".dz_clear"}, 32'(div_zero), 32'h0);
        m = 0;
        while (!done && m < 100) begin
            @(negedge clk);
            m++;
        end
        chk({tag, ".latency"}, 32'(m), dz ? 32'd1 : 32'd34);
        chk({tag, ".done"}, 32'(done), 32'h1);
        chk({tag, ".hi_lo_w"}, 32'(hi_lo_w), dz ? 32'h0 : 32'h1);
        chk({tag, ".div_zero"}, 32'(div_zero), dz ? 32'h1 : 32'h0);
        chk({tag, ".busy_done"}, 32'(busy), 32'h0);
        chk({tag, ".hi"}, hi_res, exp_hi);
        chk({tag, ".lo"}, lo_res, exp_lo);
        @(negedge clk);
        chk({tag, ".done_pulse"}, 32'(done), 32'h0);
        chk({tag, ".wr_pulse"}, 32'(hi_lo_w), 32'h0);
    endtask

    initial begin
        int n_done;
        int n_wr;
        logic [31:0] ra, rb;
        bit rop;

        reset = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        a     = 32'h0;
        b     = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst.busy", 32'(busy), 32'h0);
        chk("rst.done", 32'(done), 32'h0);
        chk("rst.hi_lo_w", 32'(hi_lo_w), 32'h0);
        chk("rst.div_zero", 32'(div_zero), 32'h0);
        chk("rst.hi", hi_res, 32'h0);
        chk("rst.lo", lo_res, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        run_op("mul_7_m3", 1'b0, 32'd7, 32'hFFFFFFFD);
        chk("mul_7_m3.hi_const", hi_res, 32'hFFFFFFFF);
        chk("mul_7_m3.lo_const", lo_res, 32'hFFFFFFEB);
        run_op("mul_min_min", 1'b0, 32'h80000000, 32'h80000000);
        chk("mul_min_min.hi_const", hi_res, 32'h40000000);
        run_op("mul_m1_m1", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("mul_m1_m1.lo_const", lo_res, 32'h1);
        run_op("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2);
        chk("div_m7_2.lo_const", lo_res, 32'hFFFFFFFD);
        chk("div_m7_2.hi_const", hi_res, 32'hFFFFFFFF);
        run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE);
        chk("div_7_m2.hi_const", hi_res, 32'h1);
        run_op("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF);
        chk("div_min_m1.lo_const", lo_res, 32'h80000000);

        run_op("pre_dz", 1'b0, 32'h1234, 32'h5678);
        run_op("div_zero", 1'b1, 32'd5, 32'h0);
        run_op("after_dz", 1'b0, 32'd6, 32'd7);

        // Restarts mid-operation must be ignored.
        start_op(1'b0, 32'd3, 32'd4);
        n_done = 0;
        n_wr   = 0;
        for (int m = 1; m <= 45; m++) begin
            @(negedge clk);
            if (done) n_done++;
            if (hi_lo_w) n_wr++;
            start = (m == 5) || (m == 20);
            a     = 32'd9;
            b     = 32'd9;
        end
        start = 1'b0;
        chk("restart.done_count", 32'(n_done), 32'd1);
        chk("restart.wr_count", 32'(n_wr), 32'd1);
        chk("restart.lo", lo_res, 32'h0000000C);
        chk("restart.hi", hi_res, 32'h0);
        exp_hi = 32'h0;
        exp_lo = 32'hC;

        // A start held high through the done cycle is accepted on the following edge.
        model(1'b0, 32'd5, 32'd6, exp_hi, exp_lo);
        start_op(1'b0, 32'd5, 32'd6);
        start = 1'b1;
        op    = 1'b0;
        a     = 32'd5;
        b     = 32'd6;
        n_done = 0;
        for (int m = 1; m <= 75; m++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        start = 1'b0;
        chk("hold_start.done_count", 32'(n_done), 32'd2);
        chk("hold_start.lo", lo_res, exp_lo);

        // Reset in the middle of a divide aborts it.
        while (done || busy) @(negedge clk);
        start_op(1'b1, 32'd1000, 32'd7);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_hi = 32'h0;
        exp_lo = 32'h0;
        chk("abort.busy", 32'(busy), 32'h0);
        chk("abort.done", 32'(done), 32'h0);
        chk("abort.hi_lo_w", 32'(hi_lo_w), 32'h0);
        chk("abort.hi", hi_res, 32'h0);
        chk("abort.lo", lo_res, 32'h0);
        n_wr = 0;
        for (int m = 0; m < 40; m++) begin
            @(negedge clk);
            if (hi_lo_w || done) n_wr++;
        end
        chk("abort.no_write", 32'(n_wr), 32'h0);
        run_op("mul_2_2", 1'b0, 32'd2, 32'd2);
        chk("mul_2_2.lo_const", lo_res, 32'd4);

        for (int i = 0; i < 30; i++) begin
            rop = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: rb = 32'h80000000;
                2: rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            ra = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
            run_op("random", rop, ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
